// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampling UART receiver (LSB first, no parity, one
// stop bit) with a held character register, framing-error flag and a sticky
// overrun flag.
//
// Handshake: charRX is a valid level that rises one cycle after a good stop
// bit is sampled and holds DataOut until the consumer drives rd_ack for one
// cycle. The clear takes effect on the following edge. rd_ack while charRX is
// low has no effect. A good stop bit arriving while a character is still held
// and unacknowledged overwrites DataOut and sets overrun. If that stop bit
// coincides with rd_ack, the new load wins and overrun is untouched.
module uart_rx_ctrl #(
    parameter int TICK_DIV  = 326,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 DataIn,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 charRX,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [1:0]           state_dbg    // 0=IDLE 1=START 2=DATA 3=STOP
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q;
    logic                   rx_s_q;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [3:0]             scnt_q, scnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   char_q, char_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   tick;

    // Next-state logic: oversample tick, frame FSM and the character holding register.
    always_comb begin
        tick     = (tcnt_q == TICK_LAST);
        tcnt_d   = tick ? '0 : tcnt_q + TW'(1);
        state_d  = state_q;
        scnt_d   = scnt_q;
        bcnt_d   = bcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        char_d   = char_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;

        // Acknowledge clears the held character; a coinciding load below overrides it.
        if (rd_ack) begin
            char_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Start edge is taken without waiting for a tick.
                if (!rx_s_q) begin
                    state_d = START;
                    scnt_d  = 4'd0;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt_q == 4'd7) begin
                        // Mid start bit: still low means a real start, high means a glitch.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            scnt_d  = 4'd0;
                            bcnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shreg_d                = shreg_q >> 1;
                        shreg_d[DATA_BITS-1]   = rx_s_q;
                        bcnt_d                 = bcnt_q + BW'(1);
                        if (bcnt_q == BIT_LAST) begin
                            state_d = STOP;
                            scnt_d  = 4'd0;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (scnt_q == 4'd15) begin
                        state_d = IDLE;
                        if (rx_s_q) begin
                            if (char_q && !rd_ack) begin
                                ovr_d = 1'b1;
                            end
                            data_d = shreg_q;
                            char_d = 1'b1;
                            ferr_d = 1'b0;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the input synchronizer, with asynchronous active-high reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            tcnt_q  <= '0;
            state_q <= IDLE;
            scnt_q  <= 4'd0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            char_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= DataIn;
            rx_s_q  <= sync1_q;
            tcnt_q  <= tcnt_d;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            char_q  <= char_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign DataOut   = data_q;
    assign charRX    = char_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames into uart_rx_ctrl with TICK_DIV=4 (64
// cycles per bit). Expected characters go into a queue as frames are sent; a
// monitor pops and compares whenever the receiver completes a frame.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int SW = DW + 3;          // {data, charRX, frame_err, overrun}
  localparam int BIT_CYC = 64;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STOP = 2'd3;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          DataIn = 1'b1;
  logic          rd_ack = 1'b0;
  logic [DW-1:0] DataOut;
  logic          charRX;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  logic [SW-1:0] exp_q[$];

  uart_rx_ctrl #(.TICK_DIV(4), .DATA_BITS(DW)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .DataIn    (DataIn),
    .rd_ack    (rd_ack),
    .DataOut   (DataOut),
    .charRX    (charRX),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    DataIn = v;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Bad stop: line held low through the stop-bit sample point, then released.
  task automatic send_frame(input logic [DW-1:0] data, input bit good_stop);
    @(posedge CLOCK_50);
    #1;
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < DW; i++) drive_bit(data[i], BIT_CYC);
    if (good_stop) begin
      drive_bit(1'b1, BIT_CYC);
    end else begin
      drive_bit(1'b0, 48);
      drive_bit(1'b1, 16);
    end
    drive_bit(1'b1, 40);
  endtask

  task automatic do_ack();
    @(posedge CLOCK_50);
    #1 rd_ack = 1'b1;
    @(negedge CLOCK_50);
    check("charrx_during_ack_cycle", charRX, 1);
    @(posedge CLOCK_50);
    #1 rd_ack = 1'b0;
    @(negedge CLOCK_50);
    check("charrx_after_ack", charRX, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dataout"}, DataOut, 0);
    check({tag, "_charrx"}, charRX, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [DW-1:0] prev_data;
  logic          prev_c;
  logic          prev_fe;
  logic [SW-1:0] got_v;
  logic [SW-1:0] exp_v;

  initial begin
    prev_data = '0;
    prev_c = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if ((charRX && !prev_c) || (DataOut !== prev_data) || (frame_err && !prev_fe)) begin
          got_v = {DataOut, charRX, frame_err, overrun};
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got data=0x%0h charRX=%0b frame_err=%0b overrun=%0b expected no event",
                     DataOut, charRX, frame_err, overrun);
          end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v) begin
              n_fail++;
              $display("FAIL frame_result: got data=0x%0h c=%0b fe=%0b ov=%0b expected data=0x%0h c=%0b fe=%0b ov=%0b",
                       got_v[SW-1:3], got_v[2], got_v[1], got_v[0],
                       exp_v[SW-1:3], exp_v[2], exp_v[1], exp_v[0]);
            end
          end
        end
      end
      prev_data = DataOut;
      prev_c = charRX;
      prev_fe = frame_err;
    end
  end

  // ---------------- stimulus ----------------
  int wait_k;

  initial begin
    // Reset state
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_reset_outputs("reset");
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1;

    // Good frame 0xA5, held until acknowledged
    exp_q.push_back({8'hA5, 1'b1, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b1);
    check("a5_charrx_held", charRX, 1);
    check("a5_dataout", DataOut, 8'hA5);
    check("a5_frame_err", frame_err, 0);
    check("a5_overrun", overrun, 0);
    do_ack();

    // Start glitch: 3 ticks low, then idle
    @(posedge CLOCK_50);
    #1 DataIn = 1'b0;
    repeat (12) @(posedge CLOCK_50);
    #1 DataIn = 1'b1;
    repeat (80) @(posedge CLOCK_50);
    #1;
    check("glitch_busy", busy, 0);
    check("glitch_state", state_dbg, ST_IDLE);
    check("glitch_charrx", charRX, 0);
    check("glitch_dataout", DataOut, 8'hA5);

    // Bad stop bit on 0x3C, then a good 0x55
    exp_q.push_back({8'hA5, 1'b0, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b0);
    check("ferr_flag", frame_err, 1);
    check("ferr_charrx", charRX, 0);
    check("ferr_dataout_kept", DataOut, 8'hA5);
    exp_q.push_back({8'h55, 1'b1, 1'b0, 1'b0});
    send_frame(8'h55, 1'b1);
    check("after_ferr_dataout", DataOut, 8'h55);
    check("after_ferr_flag", frame_err, 0);

    // 0x7E lands in the same cycle as rd_ack for the held 0x55
    exp_q.push_back({8'h7E, 1'b1, 1'b0, 1'b0});
    fork
      send_frame(8'h7E, 1'b1);
      begin
        wait_k = 0;
        while (wait_k < 2000 && state_dbg !== ST_STOP) begin
          @(posedge CLOCK_50);
          #1;
          wait_k++;
        end
        check("stop_state_reached", (state_dbg === ST_STOP), 1);
        if (state_dbg === ST_STOP) begin
          // Stop sample tick is consumed 16 ticks (64 cycles) after entering STOP.
          repeat (BIT_CYC - 1) @(posedge CLOCK_50);
          #1 rd_ack = 1'b1;
          @(posedge CLOCK_50);
          #1 rd_ack = 1'b0;
        end
      end
    join
    check("ack_load_dataout", DataOut, 8'h7E);
    check("ack_load_charrx", charRX, 1);
    check("ack_load_overrun", overrun, 0);
    do_ack();

    // Overrun: two characters with no acknowledge
    exp_q.push_back({8'h11, 1'b1, 1'b0, 1'b0});
    send_frame(8'h11, 1'b1);
    exp_q.push_back({8'h22, 1'b1, 1'b0, 1'b1});
    send_frame(8'h22, 1'b1);
    check("ovr_dataout", DataOut, 8'h22);
    check("ovr_charrx", charRX, 1);
    check("ovr_flag", overrun, 1);
    do_ack();
    check("ovr_sticky_after_ack", overrun, 1);

    // Reset in the middle of data bit 4, then a clean 0xC3
    @(posedge CLOCK_50);
    #1;
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0, BIT_CYC);
    drive_bit(1'b0, BIT_CYC / 2);
    check("busy_before_midframe_reset", busy, 1);
    reset = 1'b1;
    DataIn = 1'b1;
    @(negedge CLOCK_50);
    check_reset_outputs("midframe_reset");
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_charrx", charRX, 0);
    exp_q.push_back({8'hC3, 1'b1, 1'b0, 1'b0});
    send_frame(8'hC3, 1'b1);
    check("c3_dataout", DataOut, 8'hC3);
    check("c3_overrun", overrun, 0);

    repeat (20) @(posedge CLOCK_50);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
